audio_i2s_tx: RTL
=================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: number of clk cycles per bclk half-period; the legal range is 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; every flop SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port sample_in, input, 16 bits: signed mono PCM sample, normally driven by the preprocessor's audio_out.
REQ-005 The block SHALL have port sample_valid, input, 1 bit: sample_in holds a sample to transfer.
REQ-006 The block SHALL have port sample_ready, output, 1 bit: the holding register can accept a sample.
REQ-007 The block SHALL have port bclk, output, 1 bit: serial bit clock.
REQ-008 The block SHALL have port lrclk, output, 1 bit: word select, where 0 means left and 1 means right.
REQ-009 The block SHALL have port sdata, output, 1 bit: serial data, MSB first, I2S format.
REQ-010 The block SHALL have port underrun, output, 1 bit: one-clk pulse when a frame starts with no sample available.

Function
REQ-011 The divider SHALL behave as follows.
- div_cnt counts 0..CLK_DIV-1.
- When div_cnt == CLK_DIV-1 and clk rises: div_cnt SHALL wrap to 0 and bclk SHALL toggle.
- bclk period = 2*CLK_DIV clk cycles, 50% duty.
REQ-012 A "fall event" SHALL be the clk cycle on which bclk is driven 1->0; all of bit_cnt, lrclk, sdata and the shift register SHALL update only on fall events.
REQ-013 bit_cnt (5 bits) SHALL increment on every fall event, wrapping 31->0; lrclk SHALL be registered as bit_cnt[4] after the increment (bit_cnt 0..15 gives 0, 16..31 gives 1).
REQ-014 On each fall event sdata SHALL take shreg[31]. In the same event, shreg SHALL be loaded with {frame_sample, frame_sample} when the new bit_cnt == 0, otherwise shreg SHALL shift left by 1, filling with 0.
REQ-015 The resulting slot order SHALL be:
- at bit_cnt = 1..16, sdata carries the left word bits 15..0;
- at bit_cnt = 17..31 and then 0, sdata carries the right word bits 15..0.
- This gives the standard I2S one-bclk MSB delay after each lrclk transition.
REQ-016 The holding register SHALL be one entry (hold_data, hold_full), with sample_ready = !hold_full.
- A transfer occurs on a clk where sample_valid && sample_ready; on a transfer, hold_data <= sample_in and hold_full <= 1.
REQ-017 At the frame-load fall event (new bit_cnt == 0), handling SHALL depend on hold_full as sampled before the edge.
- hold_full = 1: frame_sample = hold_data, and hold_full SHALL clear.
- hold_full = 0: frame_sample = 16'h0000 (silence) and underrun SHALL be 1 for exactly that clk.
REQ-018 The simultaneous case SHALL be handled as follows: if a transfer and a frame load occur on the same clk, the load SHALL use the pre-edge state.
- If the holding register was empty, underrun pulses and the transferred sample is kept for the next frame.
- If it was full, no transfer can occur, because sample_ready = 0.
REQ-019 Each accepted sample SHALL be transmitted on both channels of exactly one frame; samples SHALL NOT be dropped or repeated.
REQ-020 Frame length SHALL be 64*CLK_DIV clk cycles (256 at the default), so the upstream sample rate must not exceed this.

Reset
REQ-021 While rst = 1, the following values SHALL hold at the next clk edge and be held for as long as rst stays high:
- div_cnt = 0, bclk = 0, bit_cnt = 31, lrclk = 1;
- shreg = 0, sdata = 0;
- hold_full = 0, so sample_ready = 1;
- underrun = 0.
REQ-022 Timing after release SHALL be as follows:
- The first bclk rise SHALL occur CLK_DIV cycles after rst deasserts.
- The first fall event, which is the frame load (bit_cnt 0, lrclk 0), SHALL occur 2*CLK_DIV cycles after rst deasserts.
REQ-023 Asserting rst mid-frame SHALL abandon the frame immediately and discard the holding register contents, with no underrun pulse.

Verification
REQ-024 Reset/idle scenario. Stimulus: CLK_DIV=4, release rst, sample_valid=0. Required response:
- bclk toggles every 4 clks;
- the first fall event occurs at cycle 8 with lrclk 1->0;
- underrun pulses at cycles 8 and 264;
- sdata stays 0.
REQ-025 Single-sample scenario. Stimulus: transfer 16'hA5C3 before cycle 8. Required response:
- bit_cnt 1..16 shifts 1010_0101_1100_0011;
- bit_cnt 17..31,0 repeats the same word;
- sample_ready is 0 from the transfer until cycle 8.
REQ-026 Back-to-back scenario. Stimulus: sample_valid held high with samples 16'h8000, 16'h7FFF, 16'h0001. Required response:
- the samples appear in consecutive frames, in order;
- underrun is never pulsed after the first frame.
REQ-027 Collision scenario. Stimulus: holding register empty, transfer 16'h1234 on the exact frame-load clk. Required response:
- underrun pulses and that frame is silent;
- 16'h1234 is sent in the next frame.
REQ-028 Mid-frame reset scenario. Stimulus: assert rst at bit_cnt 9 for 1 clk. Required response:
- all outputs take the REQ-021 values;
- the next frame load occurs 2*CLK_DIV clks after release.
REQ-029 Minimum-divider scenario. Stimulus: CLK_DIV=1 with a repeat of the REQ-025 scenario. Required response: bclk toggles every clk and the frame is 64 clks long.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// Mono PCM to I2S serializer. A one-entry holding register accepts samples
// upstream; each frame sends the held sample on both left and right slots.
// bclk is derived from clk by CLK_DIV, and all serial state moves only on
// the clk cycle where bclk falls.
module audio_i2s_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic               bclk,
  output logic               lrclk,
  output logic               sdata,
  output logic               underrun
);

  localparam int         DATA_W  = 16;
  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  logic [7:0]               div_cnt;
  logic [4:0]               bit_cnt;
  logic [4:0]               bit_cnt_nxt;
  logic [2*DATA_W-1:0]      shreg;
  logic signed [DATA_W-1:0] hold_data;
  logic                     hold_full;
  logic signed [DATA_W-1:0] frame_sample;
  logic                     div_wrap;
  logic                     fall_evt;
  logic                     frame_load;
  logic                     xfer;

  assign div_wrap     = (div_cnt == DIV_MAX);
  // bclk is currently high and about to toggle, so this cycle drives it low
  assign fall_evt     = div_wrap && bclk;
  assign bit_cnt_nxt  = bit_cnt + 5'd1;
  assign frame_load   = fall_evt && (bit_cnt_nxt == 5'd0);
  assign sample_ready = !hold_full;
  assign xfer         = sample_valid && !hold_full;
  // An empty holding register at frame load means a silent frame
  assign frame_sample = hold_full ? hold_data : '0;

  // Bit clock divider: toggle bclk every CLK_DIV clk cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Serializer: on each bclk fall advance the slot counter, word select and
  // shift register; sdata lags shreg[31] by one bclk for the I2S MSB delay
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 5'd31;
      lrclk   <= 1'b1;
      shreg   <= '0;
      sdata   <= 1'b0;
    end else if (fall_evt) begin
      bit_cnt <= bit_cnt_nxt;
      lrclk   <= bit_cnt_nxt[4];
      sdata   <= shreg[31];
      if (frame_load)
        shreg <= {frame_sample, frame_sample};
      else
        shreg <= {shreg[30:0], 1'b0};
    end
  end

  // Holding register occupancy and underrun flag; a frame load uses the
  // pre-edge occupancy, so a sample arriving on that same clk waits a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= frame_load && !hold_full;
      if (frame_load && hold_full)
        hold_full <= 1'b0;
      else if (xfer)
        hold_full <= 1'b1;
    end
  end

  // Holding register data capture on an accepted transfer
  always_ff @(posedge clk) begin
    if (xfer)
      hold_data <= sample_in;
  end

endmodule
